// File: rtl/credit_pkg.sv
// Shared types and width helper for the credit-link sender.
package credit_pkg;

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_WAIT_RX = 2'd1,
    S_RUN     = 2'd2
  } credit_sender_state_t;

  // A counter that must hold 0..max needs one more code than max itself.
  function automatic int credit_w(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter with synchronous clear and a sticky overflow flag.
module credit_counter
  import credit_pkg::*;
#(
  parameter  int MAX_CREDITS = 4,
  localparam int CREDIT_W    = credit_w(MAX_CREDITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                inc,
  input  logic                dec,
  output logic [CREDIT_W-1:0] count,
  output logic                overflow
);

  localparam logic [CREDIT_W-1:0] MAX_COUNT = CREDIT_W'(MAX_CREDITS);
  localparam logic [CREDIT_W-1:0] ONE       = CREDIT_W'(1);

  logic [CREDIT_W-1:0] count_q, count_d;
  logic                overflow_q, overflow_d;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (count_q == MAX_COUNT) overflow_d = 1'b1;
      else                      count_d    = count_q + ONE;
    end else if (dec && !inc) begin
      count_d = count_q - ONE;
    end
  end

  // Overflow survives clear on purpose: only a full reset forgives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop samples pre-edge values regardless of statement order.
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/credit_sender.sv
// Credit-link sender: reset handshake FSM, payload register, credit counter.
// Optional CREDIT_SENDER_BYPASS_EN lets a credit returned this cycle be spent at once.
module credit_sender
  import credit_pkg::*;
#(
  parameter  int DATA_WIDTH  = 8,
  parameter  int MAX_CREDITS = 4,
  localparam int CREDIT_W    = credit_w(MAX_CREDITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  push_valid,
  output logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_credit,
  output logic                  push_sender_in_reset,
  input  logic                  push_receiver_in_reset,
  output logic [CREDIT_W-1:0]   credit_count,
  output logic                  credit_available,
  output logic                  credit_overflow
);

  credit_sender_state_t state_q, state_d;

  logic                  push_valid_q, push_valid_d;
  logic [DATA_WIDTH-1:0] push_data_q, push_data_d;
  logic                  run_active;
  logic                  counter_clear;
  logic                  transfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:   state_d = S_WAIT_RX;
      S_WAIT_RX: if (!push_receiver_in_reset) state_d = S_RUN;
      S_RUN:     if (push_receiver_in_reset)  state_d = S_WAIT_RX;
      default:   state_d = S_RESET;
    endcase
  end

  // A receiver reset seen while running blocks the transfer in the same cycle.
  always_comb begin
    push_sender_in_reset = (state_q == S_RESET);
    run_active           = (state_q == S_RUN) && !push_receiver_in_reset;
    counter_clear        = !run_active;
`ifdef CREDIT_SENDER_BYPASS_EN
    src_ready            = run_active && (credit_available || push_credit);
`else
    src_ready            = run_active && credit_available;
`endif
  end

  assign transfer = src_valid && src_ready;

  always_comb begin
    push_valid_d = transfer;
    push_data_d  = transfer ? src_data : push_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_valid_q <= 1'b0;
      // NOTE: the payload register is reset because its value is visible at the port.
      push_data_q  <= '0;
    end else begin
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
    end
  end

  credit_counter #(
    .MAX_CREDITS (MAX_CREDITS)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (counter_clear),
    .inc      (push_credit),
    .dec      (transfer),
    .count    (credit_count),
    .overflow (credit_overflow)
  );

  assign credit_available = (credit_count != '0);
  assign push_valid       = push_valid_q;
  assign push_data        = push_data_q;

endmodule

// File: tb/tb_credit_sender.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_credit_sender;

  localparam int DW   = 8;
  localparam int MAXC = 4;
  localparam int CW   = 3;
`ifdef CREDIT_SENDER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int PH_RESET = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_RUN   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          src_valid;
  logic          src_ready;
  logic [DW-1:0] src_data;
  logic          push_valid;
  logic [DW-1:0] push_data;
  logic          push_credit;
  logic          push_sender_in_reset;
  logic          push_receiver_in_reset;
  logic [CW-1:0] credit_count;
  logic          credit_available;
  logic          credit_overflow;

  credit_sender #(
    .DATA_WIDTH  (DW),
    .MAX_CREDITS (MAXC)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .src_valid              (src_valid),
    .src_ready              (src_ready),
    .src_data               (src_data),
    .push_valid             (push_valid),
    .push_data              (push_data),
    .push_credit            (push_credit),
    .push_sender_in_reset   (push_sender_in_reset),
    .push_receiver_in_reset (push_receiver_in_reset),
    .credit_count           (credit_count),
    .credit_available       (credit_available),
    .credit_overflow        (credit_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: link phase, credits held, sticky error, last pushed word.
  int            m_phase = PH_RESET;
  int            m_cnt   = 0;
  bit            m_ovf   = 1'b0;
  bit            m_pv    = 1'b0;
  logic [DW-1:0] m_pd    = '0;

  bit            capture_en = 1'b0;
  logic [DW-1:0] seen_q[$];

  always @(negedge clk) begin : model_and_compare
    bit exp_ready;
    bit xfer;
    if (!rst_n) begin
      m_phase = PH_RESET;
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_pv    = 1'b0;
      m_pd    = '0;
    end
    exp_ready = (m_phase == PH_RUN) && !push_receiver_in_reset &&
                ((m_cnt > 0) || (BYPASS && push_credit));

    check("src_ready",            src_ready,            exp_ready);
    check("push_valid",           push_valid,           m_pv);
    check("push_data",            push_data,            m_pd);
    check("credit_count",         credit_count,         m_cnt);
    check("credit_available",     credit_available,     m_cnt != 0);
    check("credit_overflow",      credit_overflow,      m_ovf);
    check("push_sender_in_reset", push_sender_in_reset, m_phase == PH_RESET);

    if (capture_en && push_valid) seen_q.push_back(push_data);

    if (rst_n) begin
      xfer = src_valid && exp_ready;
      case (m_phase)
        PH_RESET: m_phase = PH_WAIT;
        PH_WAIT:  if (!push_receiver_in_reset) m_phase = PH_RUN;
        default: begin
          if (push_receiver_in_reset) begin
            m_phase = PH_WAIT;
            m_cnt   = 0;
          end else if (push_credit && m_cnt == MAXC && !xfer) begin
            m_ovf = 1'b1;
          end else begin
            m_cnt = m_cnt + int'(push_credit) - int'(xfer);
          end
        end
      endcase
      m_pv = xfer;
      if (xfer) m_pd = src_data;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit c, input bit rx);
    src_valid              = v;
    src_data               = d;
    push_credit            = c;
    push_receiver_in_reset = rx;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, '0, 0, 0);
    tick(3);
    rst_n = 1'b1;

    // Reset release: one cycle of sender-in-reset, then wait, then run with no credits.
    @(negedge clk);
    check("rel_sender_in_reset_hi", push_sender_in_reset, 1);
    tick();
    check("rel_sender_in_reset_lo", push_sender_in_reset, 0);
    check("rel_wait_ready", src_ready, 0);
    tick();
    check("rel_run_count", credit_count, 0);
    check("rel_run_ready", src_ready, 0);

    // Four credits, then a six-word burst: only four go out.
    drive(0, '0, 1, 0);
    tick(4);
    check("burst_count_full", credit_count, 4);
    seen_q.delete();
    capture_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1, DW'(8'h11 + i), 0, 0);
      tick();
    end
    drive(0, '0, 0, 0);
    tick();
    capture_en = 1'b0;
    check("burst_pulses", seen_q.size(), 4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++)
      check("burst_payload", seen_q[i], 8'h11 + i);
    check("burst_count_empty", credit_count, 0);
    check("burst_ready_low", src_ready, 0);

    // Credit and transfer together leave the count untouched.
    drive(0, '0, 1, 0);
    tick(2);
    drive(1, 8'hA5, 1, 0);
    tick();
    check("both_count", credit_count, 2);
    check("both_push_valid", push_valid, 1);
    check("both_push_data", push_data, 8'hA5);
    drive(0, '0, 0, 0);
    tick();
    check("both_pulse_ends", push_valid, 0);

    // Five credits from two: saturate at four and latch the error.
    drive(0, '0, 1, 0);
    tick(5);
    check("ovf_count", credit_count, 4);
    check("ovf_flag", credit_overflow, 1);
    drive(0, '0, 0, 0);
    tick(3);
    check("ovf_sticky", credit_overflow, 1);

    // Receiver reset at count three, with a push already in flight.
    drive(1, 8'h3C, 0, 0);
    tick();
    check("rxr_count3", credit_count, 3);
    drive(1, 8'h77, 0, 1);
    #1;
    check("rxr_ready_blocked", src_ready, 0);
    check("rxr_inflight", push_valid, 1);
    tick();
    check("rxr_count_cleared", credit_count, 0);
    check("rxr_no_push", push_valid, 0);
    drive(1, 8'h55, 1, 1);
    tick();
    drive(1, 8'h55, 1, 0);
    tick();
    check("rxr_credit_ignored", credit_count, 0);
    drive(1, 8'h56, 0, 0);
    tick(3);
    check("rxr_idle_push", push_valid, 0);
    check("rxr_idle_ready", src_ready, 0);
    drive(0, '0, 1, 0);
    tick();
    drive(1, 8'h57, 0, 0);
    tick();
    check("rxr_resume_push", push_valid, 1);
    check("rxr_resume_data", push_data, 8'h57);
    drive(0, '0, 0, 0);
    tick();

`ifdef CREDIT_SENDER_BYPASS_EN
    // A credit at count zero is spent the cycle it arrives.
    drive(1, 8'h9E, 1, 0);
    #1;
    check("byp_ready", src_ready, 1);
    tick();
    check("byp_push_valid", push_valid, 1);
    check("byp_push_data", push_data, 8'h9E);
    check("byp_count", credit_count, 0);
    drive(0, '0, 0, 0);
    tick();
`endif

    // Randomized traffic, receiver resets and one sender reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 59) == 0));
      if (cyc == 1500) rst_n = 1'b0;
      if (cyc == 1503) rst_n = 1'b1;
      tick();
    end

    // Asynchronous reset drops an in-flight push immediately.
    drive(0, '0, 0, 0);
    tick(3);
    drive(0, '0, 1, 0);
    tick();
    drive(1, 8'hC3, 0, 0);
    tick();
    check("async_pre_push", push_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_push_valid", push_valid, 0);
    check("async_push_data", push_data, 0);
    check("async_sender_in_reset", push_sender_in_reset, 1);
    check("async_count", credit_count, 0);
    check("async_ready", src_ready, 0);
    drive(0, '0, 0, 0);
    tick(2);
    rst_n = 1'b1;
    tick(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
